io_mem_responder: RTL



---
 rtl/io_mem_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/io_mem_responder.sv
// io_mem_responder: instruction/data memory and memory-mapped I/O for the 5-stage RISC-V core.
//
// Serves the fetch port (PC/iMemRead -> instruction) from a synchronous-read instruction RAM,
// and the data port (dAddress/dWriteData/MemRead/MemWrite -> dReadData) from a data RAM plus
// a small I/O block at IO_BASE:
//   0x00 LED (R/W, 16 bits)   0x04 SW (RO, synchronized)   0x08 BTN (RO, synchronized)
//   0x0C TIMER (ms count; write clears)   0x10 STATUS (bit0 = bus_error; write 1 clears)
// All returned data is registered (1-cycle latency). Faulting accesses set the sticky
// bus_error flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   PC, iMemRead        fetch byte address and enable; instruction is the registered word
//   dAddress, dWriteData, MemRead, MemWrite   data port; dReadData is the registered load data
//   sw, btn             asynchronous switch/button inputs
//   led                 LED register
//   bus_error           sticky fault flag
//
// Build option: define IO_TIMER_EN to build the millisecond timer at offset 0x0C. Without it,
// 0x0C reads 0 and writes there are silently ignored.

module io_mem_responder #(
  parameter int unsigned INSTR_WORDS = 1024,
  parameter int unsigned DATA_WORDS  = 1024,
  parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter string       INSTR_FILE  = "",
  parameter string       DATA_FILE   = "",
  parameter int unsigned CLK_PER_MS  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        iMemRead,
  output logic [31:0] instruction,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  input  logic [15:0] sw,
  input  logic [3:0]  btn,
  output logic [15:0] led,
  output logic        bus_error
);

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam int unsigned IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int unsigned DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  // I/O register selectors (word offset within the I/O block)
  localparam logic [2:0] RegLed    = 3'd0;
  localparam logic [2:0] RegSw     = 3'd1;
  localparam logic [2:0] RegBtn    = 3'd2;
  localparam logic [2:0] RegTimer  = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;

  logic [31:0] imem [INSTR_WORDS];
  logic [31:0] dmem [DATA_WORDS];

  // ---------------------------------------------------------------------------------------------
  // Address decode. Subtracting the base makes addresses below it wrap to huge indices, so a
  // single unsigned compare covers both ends of each region.
  // ---------------------------------------------------------------------------------------------
  logic [31:0] i_off, i_word;
  logic        i_ok;

  assign i_off  = PC - TEXT_BASE;
  assign i_word = {2'b00, i_off[31:2]};
  assign i_ok   = (i_word < INSTR_WORDS) && (i_off[1:0] == 2'b00);

  logic [31:0] d_off, d_word, io_off;
  logic        d_mis, ram_hit, io_hit, ram_ok, io_ok;
  logic [2:0]  io_reg;

  assign d_off   = dAddress - DATA_BASE;
  assign d_word  = {2'b00, d_off[31:2]};
  assign io_off  = dAddress - IO_BASE;
  assign d_mis   = (d_off[1:0] != 2'b00);
  assign ram_hit = (d_word < DATA_WORDS);
  assign io_hit  = (io_off < 32'h14);
  assign ram_ok  = ram_hit && !d_mis;
  // RAM takes priority if a parameterisation ever makes the regions overlap
  assign io_ok   = io_hit && !ram_hit && !d_mis;
  assign io_reg  = io_off[4:2];

  // ---------------------------------------------------------------------------------------------
  // Fault detection and STATUS clear
  // ---------------------------------------------------------------------------------------------
  logic fetch_fault, load_fault, store_fault, store_ro, status_clr, bus_error_d;

  assign fetch_fault = iMemRead && !i_ok;
  assign load_fault  = MemRead && !ram_ok && !io_ok;
  assign store_ro    = io_ok && ((io_reg == RegSw) || (io_reg == RegBtn));
  assign store_fault = MemWrite && ((!ram_ok && !io_ok) || store_ro);
  assign status_clr  = MemWrite && io_ok && (io_reg == RegStatus) && dWriteData[0];

  // A fault in the same cycle as a clear wins
  always_comb begin
    bus_error_d = bus_error;
    if (fetch_fault || load_fault || store_fault) begin
      bus_error_d = 1'b1;
    end else if (status_clr) begin
      bus_error_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Optional millisecond timer
  // ---------------------------------------------------------------------------------------------
  logic [31:0] timer_rd;

`ifdef IO_TIMER_EN
  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [PW-1:0] prescaler;
  logic [31:0]   timer_cnt;
  logic          timer_wr;

  assign timer_wr = MemWrite && io_ok && (io_reg == RegTimer);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      timer_cnt <= '0;
    end else if (timer_wr) begin
      // a clearing write beats a coincident wrap
      prescaler <= '0;
      timer_cnt <= '0;
    end else if (prescaler == PW'(CLK_PER_MS - 1)) begin
      prescaler <= '0;
      timer_cnt <= timer_cnt + 32'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  assign timer_rd = timer_cnt;
`else
  assign timer_rd = 32'h0;
`endif

  // ---------------------------------------------------------------------------------------------
  // I/O registers and synchronizers
  // ---------------------------------------------------------------------------------------------
  logic [15:0] sw_meta, sw_sync;
  logic [3:0]  btn_meta, btn_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      btn_meta  <= '0;
      btn_sync  <= '0;
      led       <= '0;
      bus_error <= 1'b0;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      btn_meta  <= btn;
      btn_sync  <= btn_meta;
      bus_error <= bus_error_d;
      if (MemWrite && io_ok && (io_reg == RegLed)) led <= dWriteData[15:0];
    end
  end

  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = 32'h0;
    case (io_reg)
      RegLed:    io_rdata = {16'h0, led};
      RegSw:     io_rdata = {16'h0, sw_sync};
      RegBtn:    io_rdata = {28'h0, btn_sync};
      RegTimer:  io_rdata = timer_rd;
      RegStatus: io_rdata = {31'h0, bus_error};
      default:   io_rdata = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Instruction fetch
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= Nop;
    end else if (iMemRead) begin
      instruction <= i_ok ? imem[i_word[IAW-1:0]] : Nop;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Data RAM write port and registered load path. The read samples the array before the
  // non-blocking write lands, so a simultaneous read/write returns the old word.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && MemWrite && ram_ok) dmem[d_word[DAW-1:0]] <= dWriteData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dReadData <= 32'h0;
    end else if (MemRead) begin
      if (ram_ok) begin
        dReadData <= dmem[d_word[DAW-1:0]];
      end else if (io_ok) begin
        dReadData <= io_rdata;
      end else begin
        dReadData <= 32'h0;
      end
    end
  end

endmodule
